de1_blinker_nios2_proc_oci_dct_packer: RTL and testbench
========================================================

# de1_blinker_nios2_proc_oci_dct_packer

Packs 2-bit data-trace tokens from the Nios II OCI trace path into 30-bit frames: up to 15 tokens per frame, plus a 4-bit entry count. It produces the `dct_buffer`/`dct_count` pair consumed by the OCI test bench and trace sinks. It sits between the OCI trace token source and the trace frame consumer, with valid/ready handshakes on both sides.

## Interface
- `TIMEOUT_CYCLES`, default 64, idle cycles before an automatic partial flush; legal range 2..255; used only with the timeout macro.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tok_valid`  in  1  token offered.
- `tok_data`  in  2  trace token.
- `tok_ready`  out  1  packer accepts the token this cycle.
- `flush`  in  1  single-cycle pulse; emit the partial frame.
- `frm_valid`  out  1  frame held on outputs.
- `frm_ready`  in  1  consumer takes the frame.
- `dct_buffer`  out  30  packed tokens, oldest in the highest filled position.
- `dct_count`  out  4  tokens in the frame, 1..15.

## Operation
- Accumulator state: `acc_buf[29:0]` and `acc_cnt[3:0]`.
- A token is accepted when `tok_valid && tok_ready`.
- On accept, the next accumulator values are `nbuf = {acc_buf[27:0], tok_data}` and `ncnt = acc_cnt + 1`.
  - With no accept, `nbuf`/`ncnt` equal the current values.
- Filled bits: with `n` tokens, bits `[2n-1:0]` are valid and bits above them are 0.
- Pending flush: `flush_pend` sets on a `flush` pulse and clears on launch.
  - A `flush` pulse while `ncnt == 0` is ignored and does not set `flush_pend`.
- The output slot is free when `!frm_valid || frm_ready`.
- Launch condition: slot free and (`ncnt == 15` or ((`flush` or `flush_pend` or timeout) and `ncnt != 0`)).
- On launch:
  - `dct_buffer <= nbuf`, `dct_count <= ncnt`, `frm_valid <= 1`.
  - The accumulator clears to 0 and `flush_pend` clears.
- If the slot is free and there is no launch, `frm_valid <= 0` when `frm_ready` is high.
- If there is no launch, the accumulator takes `nbuf`/`ncnt`.
- `tok_ready = (acc_cnt != 15)`.
  - The accumulator stalls only when it is full and the slot is busy.
- Frame states:
  - EMPTY: `frm_valid = 0`.
  - HELD: `frm_valid = 1`. `dct_buffer`/`dct_count` must stay stable until `frm_ready` is seen.
  - On HELD with `frm_ready` and a simultaneous launch, the next frame replaces the current one in the same cycle, with no bubble.
- Arithmetic: `acc_cnt` never exceeds 15 and there is no wrap.

## Timing
- Reset values: `frm_valid = 0`, `dct_buffer = 0`, `dct_count = 0`, `tok_ready = 1`, accumulator 0, `flush_pend = 0`, idle counter 0.
- Reset mid-frame discards the accumulator and any held frame; no frame is emitted.
- Latency: `frm_valid` rises 1 cycle after the accept of the 15th token, or 1 cycle after the `flush` cycle.
- Throughput: 1 token per clock sustained while `frm_ready = 1`.
- A token and `flush` in the same cycle: the token is included in the flushed frame.
- `tok_ready` is a registered-state function only; it has no combinational path from `tok_valid` or `flush`.

## Configuration
- `DCT_PACKER_TIMEOUT_EN` defined:
  - An 8-bit idle counter increments each cycle with `acc_cnt != 0` and no accept.
  - It resets to 0 on accept, launch, or `acc_cnt == 0`.
  - When it reaches `TIMEOUT_CYCLES - 1`, a timeout flush request is raised. The request stays until launch and then clears with the counter.
- `DCT_PACKER_TIMEOUT_EN` undefined: no counter logic; partial frames leave only on `flush`.

## Test plan
- Full frame: 15 back-to-back tokens `2'b01`, `frm_ready = 1` -> one frame, `dct_buffer = 30'h15555555`, `dct_count = 15`, `frm_valid` high for 1 cycle; `tok_ready` never drops.
- Partial flush: tokens 3, 2, 1, then a `flush` pulse -> `dct_buffer = 30'h39`, `dct_count = 3`.
  - A second `flush` with an empty accumulator -> no frame.
- Backpressure: `frm_ready = 0`, then 30 tokens `2'b10`.
  - First frame held stable: `30'h2AAAAAAA`, count 15.
  - `tok_ready` drops after the 30th accept.
  - On raising `frm_ready`, the second frame appears the next cycle, `tok_ready` returns to 1, and ordering is preserved.
- Token + flush: 4th token `2'b11` in the same cycle as `flush`, after tokens 0, 0, 0 -> `dct_count = 4`, `dct_buffer = 30'h3`.
- Timeout (macro on, `TIMEOUT_CYCLES = 64`): 2 tokens `2'b10`, then idle -> frame `30'hA`, count 2, with `frm_valid` rising 65 cycles after the last accept.
  - Macro off: no frame after 300 idle cycles.
- Reset mid-operation: 7 tokens accepted, then `reset` for 1 cycle, then `flush` -> no frame; all outputs at their reset values.

Source files
------------

// File: rtl/de1_blinker_nios2_proc_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : de1_blinker_nios2_proc_oci_dct_packer
// Purpose  : Packs 2-bit OCI data-trace tokens into 30-bit frames of up to
//            15 tokens plus a 4-bit token count (dct_buffer / dct_count).
//            The oldest token sits in the highest filled position; unfilled
//            upper bits are zero.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            tok_valid/tok_data/tok_ready - token input handshake
//            flush                  - pulse: emit the current partial frame
//            frm_valid/frm_ready    - frame output handshake
//            dct_buffer[29:0]       - packed tokens of the held frame
//            dct_count[3:0]         - number of tokens in the frame (1..15)
// Config   : DCT_PACKER_TIMEOUT_EN  - when defined, a partial frame that has
//            been idle for TIMEOUT_CYCLES cycles is flushed automatically.
// Revision : 1.0 - initial release
// ============================================================================
module de1_blinker_nios2_proc_oci_dct_packer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tok_valid,
  input  logic [1:0]  tok_data,
  output logic        tok_ready,
  input  logic        flush,
  output logic        frm_valid,
  input  logic        frm_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count
);

  localparam logic [3:0] FULL_CNT     = 4'd15;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Accumulator for the frame under construction.
  logic [29:0] acc_buf;
  logic [3:0]  acc_cnt;
  logic        flush_pend;

  // Next-state view of the accumulator including this cycle's token.
  logic        accept;
  logic [29:0] nbuf;
  logic [3:0]  ncnt;
  logic        slot_free;
  logic        flush_req;
  logic        timeout_hit;
  logic        launch;

  // Depends on registered state only, so there is no path from tok_valid
  // or flush into tok_ready.
  assign tok_ready = (acc_cnt != FULL_CNT);

  always_comb begin
    accept = tok_valid && tok_ready;
    nbuf   = acc_buf;
    ncnt   = acc_cnt;
    if (accept) begin
      nbuf = {acc_buf[27:0], tok_data};
      ncnt = acc_cnt + 4'd1;
    end
  end

  // The output register can take a new frame when it is empty or the
  // consumer is taking the current one this cycle (no bubble on replace).
  assign slot_free = !frm_valid || frm_ready;
  assign flush_req = flush || flush_pend || timeout_hit;
  assign launch    = slot_free &&
                     ((ncnt == FULL_CNT) || (flush_req && (ncnt != 4'd0)));

`ifdef DCT_PACKER_TIMEOUT_EN
  // Idle counter: counts cycles with a non-empty accumulator and no accept.
  // It saturates at the threshold so the timeout request persists while
  // the output slot is busy, and clears together with the launch.
  logic [7:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= 8'd0;
    end else if (accept || launch || (acc_cnt == 4'd0)) begin
      idle_cnt <= 8'd0;
    end else if (idle_cnt != TIMEOUT_LAST) begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end

  assign timeout_hit = (idle_cnt == TIMEOUT_LAST);
`else
  // Partial frames leave only on an explicit flush.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_LAST;
  assign timeout_hit        = 1'b0;
`endif

  // Accumulator and pending-flush tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_buf    <= 30'd0;
      acc_cnt    <= 4'd0;
      flush_pend <= 1'b0;
    end else if (launch) begin
      acc_buf    <= 30'd0;
      acc_cnt    <= 4'd0;
      flush_pend <= 1'b0;
    end else begin
      acc_buf <= nbuf;
      acc_cnt <= ncnt;
      // A flush that cannot launch yet (slot busy) is remembered; one that
      // arrives with nothing to send is dropped.
      if (flush && (ncnt != 4'd0)) begin
        flush_pend <= 1'b1;
      end
    end
  end

  // Output frame register: EMPTY when frm_valid is low, HELD otherwise.
  // Data only changes on launch, so a held frame is stable until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      frm_valid  <= 1'b0;
      dct_buffer <= 30'd0;
      dct_count  <= 4'd0;
    end else if (launch) begin
      frm_valid  <= 1'b1;
      dct_buffer <= nbuf;
      dct_count  <= ncnt;
    end else if (slot_free && frm_ready) begin
      frm_valid  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_de1_blinker_nios2_proc_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_de1_blinker_nios2_proc_oci_dct_packer
// Purpose  : Self-checking bench for the DCT trace packer. Expected frames
//            are queued when tokens are driven and compared when the DUT
//            hands a frame over (frm_valid && frm_ready).
// Revision : 1.0 - initial release
// ============================================================================
module tb_de1_blinker_nios2_proc_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tok_valid = 1'b0;
  logic [1:0]  tok_data = 2'd0;
  logic        tok_ready;
  logic        flush = 1'b0;
  logic        frm_valid;
  logic        frm_ready = 1'b1;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;

  int checks = 0;
  int errors = 0;

  // Expected frames: {count, buffer}
  logic [33:0] exp_q[$];

  de1_blinker_nios2_proc_oci_dct_packer #(.TIMEOUT_CYCLES(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .tok_valid (tok_valid),
    .tok_data  (tok_data),
    .tok_ready (tok_ready),
    .flush     (flush),
    .frm_valid (frm_valid),
    .frm_ready (frm_ready),
    .dct_buffer(dct_buffer),
    .dct_count (dct_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor plus held-frame stability check.
  logic        held_prev = 1'b0;
  logic [29:0] prev_buf = 30'd0;
  logic [3:0]  prev_cnt = 4'd0;
  logic [33:0] exp_frame;

  always @(negedge clk) begin
    if (reset) begin
      held_prev = 1'b0;
    end else begin
      if (held_prev) begin
        checks++;
        if (frm_valid !== 1'b1 || dct_buffer !== prev_buf || dct_count !== prev_cnt) begin
          errors++;
          $display("FAIL held_stable: got valid=%b buf=%h cnt=%0d, want valid=1 buf=%h cnt=%0d",
                   frm_valid, dct_buffer, dct_count, prev_buf, prev_cnt);
        end
      end
      if (frm_valid && frm_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected: got buf=%h cnt=%0d, want no frame", dct_buffer, dct_count);
        end else begin
          exp_frame = exp_q.pop_front();
          if ({dct_count, dct_buffer} !== exp_frame) begin
            errors++;
            $display("FAIL frame_data: got buf=%h cnt=%0d, want buf=%h cnt=%0d",
                     dct_buffer, dct_count, exp_frame[29:0], exp_frame[33:30]);
          end
        end
      end
      held_prev = frm_valid && !frm_ready;
      prev_buf  = dct_buffer;
      prev_cnt  = dct_count;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    tok_valid = 1'b0;
    flush = 1'b0;
    frm_ready = 1'b1;
    step();
    step();
    checks++;
    if (frm_valid !== 1'b0 || dct_buffer !== 30'd0 || dct_count !== 4'd0 || tok_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: got valid=%b buf=%h cnt=%0d rdy=%b, want 0 0 0 1",
               frm_valid, dct_buffer, dct_count, tok_ready);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_full_frame();
    frm_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tok_valid = 1'b1;
      tok_data  = 2'b01;
      checks++;
      if (tok_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_tok_ready: token %0d got %b, want 1", i, tok_ready);
      end
      if (i == 14) exp_q.push_back({4'd15, 30'h15555555});
      step();
    end
    tok_valid = 1'b0;
    checks++;
    if (frm_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_latency: frm_valid got %b, want 1", frm_valid);
    end
    step();
    checks++;
    if (frm_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_one_cycle: frm_valid got %b, want 0", frm_valid);
    end
  endtask

  task automatic test_partial_flush();
    logic [1:0] toks [3] = '{2'd3, 2'd2, 2'd1};
    for (int i = 0; i < 3; i++) begin
      tok_valid = 1'b1;
      tok_data  = toks[i];
      step();
    end
    tok_valid = 1'b0;
    flush = 1'b1;
    exp_q.push_back({4'd3, 30'h39});
    step();
    flush = 1'b0;
    checks++;
    if (frm_valid !== 1'b1) begin
      errors++;
      $display("FAIL partial_latency: frm_valid got %b, want 1", frm_valid);
    end
    step();
    // Flush with an empty accumulator must not produce a frame.
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (frm_valid !== 1'b0) begin
        errors++;
        $display("FAIL empty_flush: frm_valid got %b, want 0", frm_valid);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    frm_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tok_valid = 1'b1;
      tok_data  = 2'b10;
      checks++;
      if (tok_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_tok_ready: token %0d got %b, want 1", i, tok_ready);
      end
      if (i == 14 || i == 29) exp_q.push_back({4'd15, 30'h2AAAAAAA});
      step();
    end
    tok_valid = 1'b0;
    checks++;
    if (tok_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall: tok_ready got %b, want 0", tok_ready);
    end
    checks++;
    if (frm_valid !== 1'b1 || dct_buffer !== 30'h2AAAAAAA || dct_count !== 4'd15) begin
      errors++;
      $display("FAIL bp_held: got valid=%b buf=%h cnt=%0d, want 1 2aaaaaaa 15",
               frm_valid, dct_buffer, dct_count);
    end
    repeat (4) step();
    frm_ready = 1'b1;
    step();
    checks++;
    if (frm_valid !== 1'b1 || tok_ready !== 1'b1 || dct_count !== 4'd15) begin
      errors++;
      $display("FAIL bp_release: got valid=%b rdy=%b cnt=%0d, want 1 1 15",
               frm_valid, tok_ready, dct_count);
    end
    step();
    checks++;
    if (frm_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: frm_valid got %b, want 0", frm_valid);
    end
  endtask

  task automatic test_token_flush();
    logic [1:0] toks [4] = '{2'd0, 2'd0, 2'd0, 2'd3};
    frm_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tok_valid = 1'b1;
      tok_data  = toks[i];
      if (i == 3) begin
        flush = 1'b1;
        exp_q.push_back({4'd4, 30'h3});
      end
      step();
    end
    tok_valid = 1'b0;
    flush = 1'b0;
    checks++;
    if (frm_valid !== 1'b1 || dct_count !== 4'd4) begin
      errors++;
      $display("FAIL tokflush: got valid=%b cnt=%0d, want 1 4", frm_valid, dct_count);
    end
    step();
  endtask

  task automatic test_timeout();
    int seen_at;
    frm_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tok_valid = 1'b1;
      tok_data  = 2'b10;
      step();
    end
    tok_valid = 1'b0;
`ifdef DCT_PACKER_TIMEOUT_EN
    exp_q.push_back({4'd2, 30'hA});
    seen_at = -1;
    for (int k = 1; k <= 100; k++) begin
      if (frm_valid === 1'b1 && seen_at < 0) seen_at = k;
      step();
    end
    checks++;
    if (seen_at != 65) begin
      errors++;
      $display("FAIL timeout_latency: frame seen at %0d cycles, want 65", seen_at);
    end
`else
    seen_at = -1;
    for (int k = 1; k <= 300; k++) begin
      if (frm_valid === 1'b1 && seen_at < 0) seen_at = k;
      step();
    end
    checks++;
    if (seen_at != -1) begin
      errors++;
      $display("FAIL no_timeout: frame seen at %0d cycles, want none", seen_at);
    end
    flush = 1'b1;
    exp_q.push_back({4'd2, 30'hA});
    step();
    flush = 1'b0;
    step();
`endif
  endtask

  task automatic test_reset_mid();
    frm_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tok_valid = 1'b1;
      tok_data  = 2'(i);
      step();
    end
    tok_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (frm_valid !== 1'b0 || dct_buffer !== 30'd0 || dct_count !== 4'd0 || tok_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid: got valid=%b buf=%h cnt=%0d rdy=%b, want 0 0 0 1",
                 frm_valid, dct_buffer, dct_count, tok_ready);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [29:0] mbuf = 30'd0;
    logic [3:0]  mcnt = 4'd0;
    // Phase 1: consumer always ready, random tokens and flushes.
    frm_ready = 1'b1;
    for (int i = 0; i < 120; i++) begin
      tok_valid = ($urandom_range(0, 3) != 0);
      tok_data  = 2'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 15) == 0);
      checks++;
      if (tok_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_tok_ready: cycle %0d got %b, want 1", i, tok_ready);
      end
      if (tok_valid) begin
        mbuf = {mbuf[27:0], tok_data};
        mcnt = mcnt + 4'd1;
      end
      if (mcnt == 4'd15 || (flush && mcnt != 4'd0)) begin
        exp_q.push_back({mcnt, mbuf});
        mbuf = 30'd0;
        mcnt = 4'd0;
      end
      step();
    end
    tok_valid = 1'b0;
    flush = 1'b0;
    // Phase 2: random backpressure, full frames only.
    for (int i = 0; i < 200; i++) begin
      tok_valid = ($urandom_range(0, 3) != 0);
      tok_data  = 2'($urandom_range(0, 3));
      frm_ready = ($urandom_range(0, 1) != 0);
      if (tok_valid && tok_ready) begin
        mbuf = {mbuf[27:0], tok_data};
        mcnt = mcnt + 4'd1;
        if (mcnt == 4'd15) begin
          exp_q.push_back({mcnt, mbuf});
          mbuf = 30'd0;
          mcnt = 4'd0;
        end
      end
      step();
    end
    tok_valid = 1'b0;
    frm_ready = 1'b1;
    step();
    step();
    if (mcnt != 4'd0) exp_q.push_back({mcnt, mbuf});
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_partial_flush();
    test_backpressure();
    test_token_flush();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d frames outstanding, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
